// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state, byte width, one-hot decode helper.
// Pure declarations; no timing or flow control of its own.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Index of the set bit in a one-hot vector; returns 0 when no bit is set.
  function automatic int oh_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, one-hot winner searched from last_grant+1 upward with wrap.
// Zero latency; no flow control, output is all-zero when no request is present.
module uart_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDX_W'((int'(last_grant) + i) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked sharing of one UART byte stream; grant 1 cycle after request, byte out 1 cycle after accept.
// Owner ready follows the one-entry buffer (empty or draining); optional stalled-lock revocation under UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int MAX_BURST      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [BYTE_W*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    tx_valid_o,
  output logic [BYTE_W-1:0]       tx_data_o,
  input  logic                    tx_ready_i,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BURST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

  if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t          state_q, state_d;
  logic [N_REQ-1:0]    grant_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic [BURST_W-1:0]  burst_q;
  logic                tx_valid_q;
  logic [BYTE_W-1:0]   tx_data_q;
  logic [N_REQ-1:0]    pick;

  logic                own_valid;
  logic                own_last;
  logic [BYTE_W-1:0]   own_data;
  logic                buf_free;
  logic                accept;
  logic                burst_done;
  logic                tmo_hit;
  logic                release_lock;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req_valid_i),
    .last_grant (last_grant_q),
    .gnt        (pick)
  );

  always_comb begin
    own_valid = |(req_valid_i & grant_q);
    own_last  = |(req_last_i & grant_q);
    own_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) own_data = own_data | req_data_i[BYTE_W*k +: BYTE_W];
    end
  end

  // A full buffer can still take a byte in the same cycle it drains.
  assign buf_free = ~tx_valid_q | tx_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (|req_valid_i) state_d = ARB_LOCKED;
      ARB_LOCKED: if (release_lock) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = '0;
    accept       = 1'b0;
    burst_done   = 1'b0;
    release_lock = 1'b0;
    if (state_q == ARB_LOCKED) begin
      req_ready_o  = grant_q & {N_REQ{buf_free}};
      accept       = own_valid & buf_free;
      burst_done   = (MAX_BURST != 0) && (burst_q == BURST_LAST);
      release_lock = (accept & (own_last | burst_done)) | tmo_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
    end else if (state_q == ARB_IDLE && |req_valid_i) begin
      grant_q <= pick;
    end else if (release_lock) begin
      grant_q      <= '0;
      last_grant_q <= IDX_W'(oh_to_idx(32'(grant_q)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            burst_q <= '0;
    else if (release_lock) burst_q <= '0;
    else if (accept)       burst_q <= burst_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else if (accept) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= own_data;
    end else if (tx_ready_i) begin
      tx_valid_q <= 1'b0;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q;
  logic             timeout_q;

  // Counts consecutive owner-idle cycles; the final one revokes the lock.
  assign tmo_hit = (state_q == ARB_LOCKED) && !own_valid && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit;
      if (state_q != ARB_LOCKED || own_valid || tmo_hit) tmo_q <= '0;
      else                                                tmo_q <= tmo_q + 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign grant_o    = grant_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = (state_q != ARB_IDLE) | tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=2, MAX_BURST=4, TIMEOUT_CYCLES=16); requester queues feed the DUT,
// the serializer side is captured into a byte stream compared against hand-written expected sequences.
module tb_uart_tx_arbiter;

  localparam int N_REQ          = 2;
  localparam int MAX_BURST      = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic        timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ          (N_REQ),
    .MAX_BURST      (MAX_BURST),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] txq[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc0 = 0;
  int tmo_pulses = 0;
  int switch_bad = 0;
  int ready_bad = 0;
  int stall_bad = 0;
  logic [1:0] prev_g = 2'b00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input int k, input logic [7:0] b, input logic l);
    if (k == 0) q0.push_back({l, b});
    else        q1.push_back({l, b});
  endtask

  task automatic drive();
    req_valid = 2'b00;
    req_data  = 16'h0000;
    req_last  = 2'b00;
    if (q0.size() != 0) begin
      req_valid[0]   = 1'b1;
      req_data[7:0]  = q0[0][7:0];
      req_last[0]    = q0[0][8];
    end
    if (q1.size() != 0) begin
      req_valid[1]   = 1'b1;
      req_data[15:8] = q1[0][7:0];
      req_last[1]    = q1[0][8];
    end
  endtask

  // Called at posedge+1; samples handshakes just before the next edge.
  task automatic step();
    logic a0, a1, ta;
    logic [7:0] td;
    drive();
    #3;
    a0 = req_valid[0] & req_ready[0];
    a1 = req_valid[1] & req_ready[1];
    ta = tx_valid & tx_ready;
    td = tx_data;
    if ((req_ready & ~grant) != 2'b00) ready_bad++;
    @(posedge clk);
    cyc++;
    #1;
    if (a0) begin
      void'(q0.pop_front());
      acc_cyc0 = cyc;
    end
    if (a1) void'(q1.pop_front());
    if (ta) txq.push_back(td);
    if (timeout) tmo_pulses++;
    if (prev_g != 2'b00 && grant != 2'b00 && grant != prev_g) switch_bad++;
    prev_g = grant;
    drive();
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || tx_valid) && n < max) begin
      step();
      n++;
    end
    chk({tag, "_bound"}, 32'(n < max), 32'd1);
  endtask

  task automatic chk_stream(input string tag, input int n, input logic [95:0] exp);
    chk({tag, "_len"}, 32'(txq.size()), 32'(n));
    for (int i = 0; i < n && i < txq.size(); i++)
      chk({tag, "_byte"}, 32'(txq[i]), 32'(exp[8*(n-1-i) +: 8]));
    txq.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_data  = 16'hA55A;
    req_last  = 2'b00;
    tx_ready  = 1'b0;

    // Reset state, with requests already asserted
    #3;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_grant_held", 32'(grant), 32'h0);
    rst_n = 1'b1;
    drive();

    // Tie right after reset: req0 first, whole messages, no interleave
    tx_ready = 1'b1;
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b1);
    step();
    chk("t3a_first_grant", 32'(grant), 32'h1);
    drain("t3a", 60);
    chk_stream("t3a", 6, {8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13});

    // "OK\n" from req0 alone
    push(0, 8'h4F, 1'b0); push(0, 8'h4B, 1'b0); push(0, 8'h0A, 1'b1);
    step();
    chk("t2_grant", 32'(grant), 32'h1);
    drain("t2", 40);
    chk_stream("t2", 3, {8'h4F, 8'h4B, 8'h0A});
    chk("t2_grant_release", 32'(grant), 32'h0);
    chk("t2_busy", 32'(busy), 32'h0);

    // req0 owned last, so the next tie goes to req1
    push(0, 8'h21, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h23, 1'b1);
    push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
    drain("t3b", 60);
    chk_stream("t3b", 6, {8'h31, 8'h32, 8'h33, 8'h21, 8'h22, 8'h23});

    // Burst limit 4: req0 streams 10 bytes without last while req1 waits
    for (int i = 0; i < 10; i++) push(0, 8'hA0 + 8'(i), 1'b0);
    step();
    chk("t4_grant", 32'(grant), 32'h1);
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
    drain("t4", 100);
    chk_stream("t4", 12, {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1,
                          8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9});
    chk("t4_lock_kept", 32'(grant), 32'h1);

    // req0 now holds the lock with no last; req1 pending
    push(1, 8'hC0, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!timeout && n < 40) begin
        step();
        n++;
      end
      chk("t6_bound", 32'(n < 40), 32'd1);
      chk("t6_idle_cycles", 32'(cyc - acc_cyc0), 32'(TIMEOUT_CYCLES));
      chk("t6_grant_drop", 32'(grant), 32'h0);
      chk("t6_no_req1_byte", 32'(txq.size()), 32'h0);
      step();
      chk("t6_pulse_width", 32'(timeout), 32'h0);
      chk("t6_req1_grant", 32'(grant), 32'h2);
      drain("t6", 20);
      chk_stream("t6", 1, {8'hC0});
      chk("t6_pulse_count", 32'(tmo_pulses), 32'h1);
    end
`else
    repeat (30) step();
    chk("t6_lock_held", 32'(grant), 32'h1);
    chk("t6_no_timeout", 32'(tmo_pulses), 32'h0);
    chk("t6_no_req1_byte", 32'(txq.size()), 32'h0);
    push(0, 8'hD0, 1'b1);
    drain("t6", 20);
    chk_stream("t6", 2, {8'hD0, 8'hC0});
`endif

    // Serializer stalls 20 cycles with a full buffer
    tx_ready = 1'b0;
    push(0, 8'hE0, 1'b0); push(0, 8'hE1, 1'b0); push(0, 8'hE2, 1'b1);
    step();
    step();
    chk("t5_buf_full", 32'(tx_valid), 32'h1);
    repeat (20) begin
      step();
      if (tx_data !== 8'hE0 || req_ready !== 2'b00 || tx_valid !== 1'b1) stall_bad++;
    end
    chk("t5_stall_stable", 32'(stall_bad), 32'h0);
    chk("t5_pending", 32'(q0.size()), 32'h2);
    chk("t5_nothing_out", 32'(txq.size()), 32'h0);
    tx_ready = 1'b1;
    drain("t5", 20);
    chk_stream("t5", 3, {8'hE0, 8'hE1, 8'hE2});

    // Asynchronous reset in the middle of a message
    tx_ready = 1'b0;
    push(0, 8'hF0, 1'b0); push(0, 8'hF1, 1'b1);
    step();
    step();
    chk("t1_pre_tx_valid", 32'(tx_valid), 32'h1);
    chk("t1_pre_grant", 32'(grant), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t1_tx_valid", 32'(tx_valid), 32'h0);
    chk("t1_tx_data", 32'(tx_data), 32'h00);
    chk("t1_grant", 32'(grant), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_ready", 32'(req_ready), 32'h0);
    chk("t1_timeout", 32'(timeout), 32'h0);
    q0.delete();
    q1.delete();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_g = 2'b00;
    tx_ready = 1'b1;
    repeat (5) step();
    chk("t1_no_replay", 32'(txq.size()), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    chk("ready_only_owner", 32'(ready_bad), 32'h0);
    chk("release_gap", 32'(switch_bad), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
